// File: rtl/updown_rate_counter.sv
// Up/down counter that steps at a prescaled rate chosen from four dividers.
// Supports wrap or saturate mode, synchronous parallel load and enable.
// TICK marks every step and TC marks a wrap or a saturate arrival.
// All outputs are registered. Reset is synchronous and active-high.
module updown_rate_counter #(
    parameter int WIDTH = 8,
    parameter int DIV0  = 25000,
    parameter int DIV1  = 12500,
    parameter int DIV2  = 6250,
    parameter int DIV3  = 3125
) (
    input  logic             CLK50MHz,
    input  logic             RST,
    input  logic             EN,
    input  logic             S0,
    input  logic [1:0]       S1,
    input  logic             MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] Q,
    output logic             TICK,
    output logic             TC
);

    localparam int MAX01   = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int MAX23   = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int MAX_DIV = (MAX01 > MAX23) ? MAX01 : MAX23;
    // A zero-width prescaler is not legal, so all-ones dividers still get one bit.
    localparam int PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [WIDTH-1:0] Q_MAX    = '1;
    localparam logic [WIDTH-1:0] Q_PENULT = Q_MAX - 1'b1;
    localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);

    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;
    logic [1:0]       s1_q;
    logic [PW-1:0]    div_last;

    // Terminal prescaler value for the currently selected rate.
    always_comb begin
        unique case (S1)
            2'd0:    div_last = PW'(DIV0 - 1);
            2'd1:    div_last = PW'(DIV1 - 1);
            2'd2:    div_last = PW'(DIV2 - 1);
            default: div_last = PW'(DIV3 - 1);
        endcase
    end

    // Next-state logic. LOAD outranks a rate change, and a rate change outranks stepping.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        p_d    = p_q;
        q_d    = q_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        if (LOAD) begin
            q_d = LOAD_VAL;
            p_d = '0;
        end else if (S1 != s1_q) begin
            // Restart the prescaler on any rate change, even while frozen.
            // This keeps P from ever sitting above the new terminal value.
            p_d = '0;
        end else if (EN) begin
            if (p_q == div_last) begin
                p_d    = '0;
                tick_d = 1'b1;
                if (S0) begin
                    if (q_q != Q_MAX) begin
                        q_d  = q_q + 1'b1;
                        tc_d = MODE && (q_q == Q_PENULT);
                    end else if (!MODE) begin
                        q_d  = '0;
                        tc_d = 1'b1;
                    end
                end else begin
                    if (q_q != '0) begin
                        q_d  = q_q - 1'b1;
                        tc_d = MODE && (q_q == Q_ONE);
                    end else if (!MODE) begin
                        q_d  = Q_MAX;
                        tc_d = 1'b1;
                    end
                end
            end else begin
                p_d = p_q + 1'b1;
            end
        end
    end

    // State registers, with a synchronous reset that has top priority.
    always_ff @(posedge CLK50MHz) begin
        // NOTE: non-blocking assignments let every register update from pre-edge values.
        if (RST) begin
            p_q    <= '0;
            q_q    <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
            s1_q   <= 2'd0;
        end else begin
            p_q    <= p_d;
            q_q    <= q_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
            s1_q   <= S1;
        end
    end

    assign Q    = q_q;
    assign TICK = tick_q;
    assign TC   = tc_q;

endmodule

// File: tb/tb_updown_rate_counter.sv
// Self-checking bench for updown_rate_counter with small dividers.
// A behavioural model counts enabled clocks since the last restart.
// It predicts Q, TICK and TC, which are compared with the DUT on every falling edge.
// Directed sections pin both the model and the DUT to hand-derived literal values.
module tb_updown_rate_counter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         s0 = 1'b1;
    logic [1:0]   s1 = 2'd0;
    logic         mode = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic         tick;
    logic         tc;

    int vectors = 0;
    int miscompares = 0;

    updown_rate_counter #(
        .WIDTH(W), .DIV0(4), .DIV1(2), .DIV2(3), .DIV3(1)
    ) dut (
        .CLK50MHz(clk),
        .RST(rst),
        .EN(en),
        .S0(s0),
        .S1(s1),
        .MODE(mode),
        .LOAD(load),
        .LOAD_VAL(load_val),
        .Q(q),
        .TICK(tick),
        .TC(tc)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int  m_q = 0;       // counter value as a plain integer
    int  m_phase = 0;   // enabled clocks since the last step or restart
    int  m_s1h = 0;     // rate seen at the previous edge
    bit  m_tick = 0;
    bit  m_tc = 0;
    bit  m_valid = 0;
    localparam int MAXV = (1 << W) - 1;

    function automatic int div_of(input int sel);
        case (sel)
            0: return 4;
            1: return 2;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk) begin
        int sel;
        sel = int'(s1);
        m_tick = 0;
        m_tc = 0;
        if (rst) begin
            m_q = 0;
            m_phase = 0;
            m_s1h = 0;
        end else begin
            if (load) begin
                m_q = int'(load_val);
                m_phase = 0;
            end else if (sel != m_s1h) begin
                m_phase = 0;
            end else if (en) begin
                m_phase = m_phase + 1;
                if (m_phase == div_of(sel)) begin
                    m_phase = 0;
                    m_tick = 1;
                    if (s0) begin
                        if (m_q < MAXV) begin
                            m_q = m_q + 1;
                            m_tc = mode && (m_q == MAXV);
                        end else if (!mode) begin
                            m_q = 0;
                            m_tc = 1;
                        end
                    end else begin
                        if (m_q > 0) begin
                            m_q = m_q - 1;
                            m_tc = mode && (m_q == 0);
                        end else if (!mode) begin
                            m_q = MAXV;
                            m_tc = 1;
                        end
                    end
                end
            end
            m_s1h = sel;
        end
        m_valid = 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model comparison on every cycle once the model has seen an edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_Q", 32'(q), 32'(m_q));
            check("model_TICK", 32'(tick), 32'(m_tick));
            check("model_TC", 32'(tc), 32'(m_tc));
        end
    end

    // Pin DUT and model to literal values. Callers run this at a falling edge.
    task automatic expect_lit(input string name, input int eq, input bit et, input bit ec);
        check({name, "_Q"}, 32'(q), 32'(eq));
        check({name, "_TICK"}, 32'(tick), 32'(et));
        check({name, "_TC"}, 32'(tc), 32'(ec));
        check({name, "_mQ"}, 32'(m_q), 32'(eq));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    int hist;
    int q_before;

    initial begin
        // Reset held for three clocks.
        rst = 1'b1;
        repeat (3) cyc();
        expect_lit("reset", 0, 0, 0);

        // Slowest rate up-count: one step every 4 clocks.
        rst = 1'b0; en = 1'b1; s0 = 1'b1; s1 = 2'd0; mode = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            repeat (3) begin
                cyc();
                expect_lit("upcount_idle", k - 1, 0, 0);
            end
            cyc();
            expect_lit("upcount_step", k, 1, 0);
        end

        // Wrap in both directions at one step per clock.
        load = 1'b1; load_val = 8'hFE; s1 = 2'd3;
        cyc(); expect_lit("wrap_load", 8'hFE, 0, 0);
        load = 1'b0;
        cyc(); expect_lit("wrap_up_ff", 8'hFF, 1, 0);
        cyc(); expect_lit("wrap_up_00", 8'h00, 1, 1);
        cyc(); expect_lit("wrap_up_01", 8'h01, 1, 0);
        s0 = 1'b0;
        cyc(); expect_lit("wrap_dn_00", 8'h00, 1, 0);
        cyc(); expect_lit("wrap_dn_ff", 8'hFF, 1, 1);
        cyc(); expect_lit("wrap_dn_fe", 8'hFE, 1, 0);

        // Saturation at both bounds. TC fires once, on arrival.
        mode = 1'b1; load = 1'b1; load_val = 8'hFD; s0 = 1'b1;
        cyc(); expect_lit("sat_load", 8'hFD, 0, 0);
        load = 1'b0;
        cyc(); expect_lit("sat_up_fe", 8'hFE, 1, 0);
        cyc(); expect_lit("sat_up_ff", 8'hFF, 1, 1);
        cyc(); expect_lit("sat_up_hold1", 8'hFF, 1, 0);
        cyc(); expect_lit("sat_up_hold2", 8'hFF, 1, 0);
        load = 1'b1; load_val = 8'h02; s0 = 1'b0;
        cyc(); expect_lit("sat_load_dn", 8'h02, 0, 0);
        load = 1'b0;
        cyc(); expect_lit("sat_dn_01", 8'h01, 1, 0);
        cyc(); expect_lit("sat_dn_00", 8'h00, 1, 1);
        cyc(); expect_lit("sat_dn_hold", 8'h00, 1, 0);

        // Switch rate mid-count: back to rate 0, run to P=2, then go to rate 1.
        mode = 1'b0; s0 = 1'b1; s1 = 2'd0;
        cyc(); expect_lit("rate_change0", 8'h00, 0, 0);
        repeat (2) begin
            cyc(); expect_lit("rate_ramp", 8'h00, 0, 0);
        end
        s1 = 2'd1;
        cyc(); expect_lit("rate_switch", 8'h00, 0, 0);
        cyc(); expect_lit("rate_wait", 8'h00, 0, 0);
        cyc(); expect_lit("rate_step1", 8'h01, 1, 0);
        cyc(); expect_lit("rate_wait2", 8'h01, 0, 0);
        cyc(); expect_lit("rate_step2", 8'h02, 1, 0);

        // LOAD wins over a step that is due, then check freeze and load while frozen.
        s1 = 2'd3;
        cyc(); expect_lit("prio_rate3", 8'h02, 0, 0);
        load = 1'b1; load_val = 8'h5A;
        cyc(); expect_lit("prio_load_due", 8'h5A, 0, 0);
        load = 1'b0; en = 1'b0;
        repeat (10) begin
            cyc(); expect_lit("prio_frozen", 8'h5A, 0, 0);
        end
        load = 1'b1; load_val = 8'h33;
        cyc(); expect_lit("prio_load_en0", 8'h33, 0, 0);

        // Reset beats a simultaneous LOAD, and the first step comes DIV0 clocks later.
        load_val = 8'h40;
        cyc(); expect_lit("rst_preload", 8'h40, 0, 0);
        rst = 1'b1; load_val = 8'h77; s1 = 2'd0;
        cyc(); expect_lit("rst_mid", 8'h00, 0, 0);
        rst = 1'b0; load = 1'b0; en = 1'b1; s0 = 1'b1; mode = 1'b0;
        repeat (3) begin
            cyc(); expect_lit("rst_release_idle", 8'h00, 0, 0);
        end
        cyc(); expect_lit("rst_release_step", 8'h01, 1, 0);
        q_before = int'(q);

        // Randomised run against the model. A rate change is only applied with EN=1.
        hist = int'(s1);
        for (int n = 0; n < 3000; n++) begin
            int pick;
            rst  = ($urandom_range(199) == 0);
            load = ($urandom_range(19) == 0);
            if ($urandom_range(29) == 0) s1 = 2'($urandom_range(3));
            en = ($urandom_range(7) != 0);
            if ($urandom_range(15) == 0) s0 = ~s0;
            if ($urandom_range(39) == 0) mode = ~mode;
            pick = $urandom_range(4);
            case (pick)
                0: load_val = 8'h00;
                1: load_val = 8'h01;
                2: load_val = 8'hFE;
                3: load_val = 8'hFF;
                default: load_val = 8'($urandom_range(255));
            endcase
            if (int'(s1) != hist) en = 1'b1;
            hist = rst ? 0 : int'(s1);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
